// File: rtl/cpu_trap_ctrl_if.sv
// Trap controller bus: retire-stage trap/MRET requests, CSR snapshots, and
// the controller's CSR write port, pipeline controls and mstatus bits.
//   master : core side, drives requests and CSR snapshots, sees controls
//   slave  : trap controller side
interface cpu_trap_ctrl_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned IRQ_W  = 3;

  // Requests from the retiring instruction / interrupt lines
  logic              exc_valid;
  logic [CODE_W-1:0] exc_code;
  logic [XLEN-1:0]   exc_pc;
  logic              mret;
  logic [IRQ_W-1:0]  irq_pending;   // {meip, mtip, msip}
  logic [XLEN-1:0]   resume_pc;

  // Live CSR values
  logic [XLEN-1:0]   mie;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   mepc;

  // Controller outputs
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_wenable;
  logic              flush;
  logic              busy;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              mstatus_mie;
  logic              mstatus_mpie;

  modport master (
    output exc_valid, exc_code, exc_pc, mret, irq_pending, resume_pc,
    output mie, mtvec, mepc,
    input  csr_waddr, csr_wdata, csr_wenable, flush, busy,
    input  redirect_valid, redirect_pc, mstatus_mie, mstatus_mpie
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, mret, irq_pending, resume_pc,
    input  mie, mtvec, mepc,
    output csr_waddr, csr_wdata, csr_wenable, flush, busy,
    output redirect_valid, redirect_pc, mstatus_mie, mstatus_mpie
  );
endinterface

// File: rtl/cpu_trap_ctrl.sv
// Machine-mode trap sequencer. Accepts an exception, an enabled interrupt or
// an MRET from the retire stage, then walks a fixed sequence: write mepc,
// write mcause, redirect to mtvec (direct or vectored); MRET redirects to mepc.
// Owns mstatus.MIE / mstatus.MPIE.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - cpu_trap_ctrl_if.slave (requests in, CSR write/flush/redirect out)
module cpu_trap_ctrl #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
  input logic           clk,
  input logic           rst_n,
  cpu_trap_ctrl_if.slave bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned IRQ_W  = 3;

  localparam logic [CODE_W-1:0] CODE_MEI = CODE_W'(11);
  localparam logic [CODE_W-1:0] CODE_MSI = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_MTI = CODE_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    REDIRECT,
    RET
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              intr_q, intr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              mie_q, mie_d;
  logic              mpie_q, mpie_d;

  logic [IRQ_W-1:0]  irq_en_c;
  logic              irq_take_c;
  logic [CODE_W-1:0] irq_code_c;
  logic [XLEN-1:0]   vec_off_c;

  logic              flush_c;
  logic              wen_c;
  logic [CSR_AW-1:0] waddr_c;
  logic [XLEN-1:0]   wdata_c;
  logic              rv_c;
  logic [XLEN-1:0]   rpc_c;
  logic              unused_mie_c;

  // Pending lines masked by their mie enables, in {meip, mtip, msip} order
  assign irq_en_c   = bus.irq_pending & {bus.mie[11], bus.mie[7], bus.mie[3]};
  assign irq_take_c = mie_q & (|irq_en_c);

  // Only the three machine-level enable bits matter here
  assign unused_mie_c = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};

  // Interrupt priority: MEI > MSI > MTI
  always_comb begin
    irq_code_c = CODE_MTI;
    if (irq_en_c[2]) begin
      irq_code_c = CODE_MEI;
    end else if (irq_en_c[0]) begin
      irq_code_c = CODE_MSI;
    end
  end

  // Vectored mode adds 4*cause, interrupts only
  assign vec_off_c = (intr_q && (bus.mtvec[1:0] == 2'b01)) ? XLEN'({code_q, 2'b00}) : '0;

  // State and latched trap context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      intr_q  <= 1'b0;
      pc_q    <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      intr_q  <= intr_d;
      pc_q    <= pc_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
    end
  end

  // Next state and per-state controls
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    intr_d  = intr_q;
    pc_d    = pc_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    flush_c = 1'b0;
    wen_c   = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    rv_c    = 1'b0;
    rpc_c   = '0;

    case (state_q)
      IDLE: begin
        // Exception wins over interrupts and over a simultaneous MRET
        if (bus.exc_valid) begin
          flush_c = 1'b1;
          code_d  = bus.exc_code;
          intr_d  = 1'b0;
          pc_d    = bus.exc_pc;
          state_d = SAVE_EPC;
        end else if (irq_take_c) begin
          flush_c = 1'b1;
          code_d  = irq_code_c;
          intr_d  = 1'b1;
          pc_d    = bus.resume_pc;
          state_d = SAVE_EPC;
        end else if (bus.mret) begin
          flush_c = 1'b1;
          state_d = RET;
        end
      end
      SAVE_EPC: begin
        wen_c   = 1'b1;
        waddr_c = MEPC_ADDR;
        wdata_c = {pc_q[XLEN-1:2], 2'b00};
        state_d = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        wen_c   = 1'b1;
        waddr_c = MCAUSE_ADDR;
        wdata_c = {intr_q, 27'b0, code_q};
        state_d = REDIRECT;
      end
      REDIRECT: begin
        rv_c    = 1'b1;
        rpc_c   = {bus.mtvec[XLEN-1:2], 2'b00} + vec_off_c;
        mpie_d  = mie_q;
        mie_d   = 1'b0;
        state_d = IDLE;
      end
      RET: begin
        rv_c    = 1'b1;
        rpc_c   = bus.mepc;
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // flush is decoded from live inputs in IDLE, so gate it during reset
  assign bus.flush          = flush_c & rst_n;
  assign bus.csr_wenable    = wen_c;
  assign bus.csr_waddr      = waddr_c;
  assign bus.csr_wdata      = wdata_c;
  assign bus.redirect_valid = rv_c;
  assign bus.redirect_pc    = rpc_c;
  assign bus.busy           = (state_q != IDLE);
  assign bus.mstatus_mie    = mie_q;
  assign bus.mstatus_mpie   = mpie_q;
endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Self-checking bench for cpu_trap_ctrl: directed scenarios plus randomized
// transactions checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_cpu_trap_ctrl;
  localparam logic [11:0] MEPC_A   = 12'h341;
  localparam logic [11:0] MCAUSE_A = 12'h342;
  localparam int unsigned OW       = 82;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_trap_ctrl_if bus();

  cpu_trap_ctrl #(.MEPC_ADDR(MEPC_A), .MCAUSE_ADDR(MCAUSE_A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model of the architectural mstatus bits
  logic m_mie, m_mpie;

  // Values seen in the last transaction, for directed checks
  logic [31:0] seen_mepc, seen_mcause, seen_rpc;
  int          seen_kind;

  function automatic logic [OW-1:0] pack(input logic f, input logic b, input logic we,
                                         input logic [11:0] wa, input logic [31:0] wd,
                                         input logic rv, input logic [31:0] rp,
                                         input logic mi, input logic mp);
    return {f, b, we, wa, wd, rv, rp, mi, mp};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.flush, bus.busy, bus.csr_wenable, bus.csr_waddr, bus.csr_wdata,
            bus.redirect_valid, bus.redirect_pc, bus.mstatus_mie, bus.mstatus_mpie};
  endfunction

  task automatic drive_zero();
    bus.exc_valid   = 1'b0;
    bus.exc_code    = '0;
    bus.exc_pc      = '0;
    bus.mret        = 1'b0;
    bus.irq_pending = '0;
    bus.resume_pc   = '0;
    bus.mie         = '0;
    bus.mtvec       = '0;
    bus.mepc        = '0;
  endtask

  // Inputs the controller must ignore while busy
  task automatic rnd_ignored();
    bus.exc_valid   = 1'($urandom);
    bus.exc_code    = 4'($urandom);
    bus.exc_pc      = $urandom;
    bus.mret        = 1'($urandom);
    bus.irq_pending = 3'($urandom);
    bus.resume_pc   = $urandom;
  endtask

  // Apply one request in an idle cycle and follow the whole sequence.
  // Entry/exit: 1ns after a rising edge with the controller idle.
  task automatic do_txn(input logic ev, input logic [3:0] ec, input logic [31:0] epc,
                        input logic mr, input logic [2:0] ip, input logic [31:0] rsm,
                        input logic [31:0] mie_v, input logic [31:0] mtvec_v,
                        input logic [31:0] mepc_v);
    int kind;
    int nph;
    logic ti;
    logic [3:0] tc;
    logic [31:0] tp, vec;
    logic [OW-1:0] exp_v, got;

    kind = 0; ti = 1'b0; tc = '0; tp = '0;
    if (ev) begin
      kind = 1; tc = ec; tp = epc;
    end else if (m_mie && ((ip[2] & mie_v[11]) || (ip[1] & mie_v[7]) || (ip[0] & mie_v[3]))) begin
      kind = 1; ti = 1'b1; tp = rsm;
      if (ip[2] && mie_v[11])     tc = 4'd11;
      else if (ip[0] && mie_v[3]) tc = 4'd3;
      else                        tc = 4'd7;
    end else if (mr) begin
      kind = 2;
    end
    vec = mtvec_v & 32'hFFFF_FFFC;
    if (ti && mtvec_v[1:0] == 2'b01) vec = vec + 32'(tc) * 32'd4;
    nph = (kind == 1) ? 3 : (kind == 2) ? 1 : 0;

    bus.exc_valid = ev;  bus.exc_code = ec;   bus.exc_pc = epc;
    bus.mret = mr;       bus.irq_pending = ip; bus.resume_pc = rsm;
    bus.mie = mie_v;     bus.mtvec = mtvec_v;  bus.mepc = mepc_v;
    #3;
    seen_kind = kind; seen_mepc = '0; seen_mcause = '0; seen_rpc = '0;
    for (int p = 0; p <= nph; p++) begin
      if (p > 0) begin
        @(posedge clk); #1;
        rnd_ignored();
        #3;
      end
      if (p == 0)
        exp_v = pack(kind != 0, 1'b0, 1'b0, '0, '0, 1'b0, '0, m_mie, m_mpie);
      else if (kind == 2)
        exp_v = pack(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, mepc_v, m_mie, m_mpie);
      else if (p == 1)
        exp_v = pack(1'b0, 1'b1, 1'b1, MEPC_A, tp & 32'hFFFF_FFFC, 1'b0, '0, m_mie, m_mpie);
      else if (p == 2)
        exp_v = pack(1'b0, 1'b1, 1'b1, MCAUSE_A, {ti, 27'b0, tc}, 1'b0, '0, m_mie, m_mpie);
      else
        exp_v = pack(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, vec, m_mie, m_mpie);
      got = obs();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL txn kind=%0d phase=%0d got=%h exp=%h", kind, p, got, exp_v);
      end
      if (kind == 1 && p == 1) seen_mepc = bus.csr_wdata;
      if (kind == 1 && p == 2) seen_mcause = bus.csr_wdata;
      if (p == nph && nph > 0) seen_rpc = bus.redirect_pc;
    end
    @(posedge clk); #1;
    if (kind == 1) begin
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (kind == 2) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end
  endtask

  // Two MRETs always leave MIE=MPIE=1
  task automatic set_mie_on();
    do_txn(1'b0, '0, '0, 1'b1, '0, '0, '0, 32'h8000, 32'h40);
    do_txn(1'b0, '0, '0, 1'b1, '0, '0, '0, 32'h8000, 32'h40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_zero();
    bus.exc_valid = 1'b1; bus.mret = 1'b1; bus.irq_pending = 3'b111; bus.mie = '1;
    #3;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_early got=%h exp=0", obs());
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_clocked got=%h exp=0", obs());
    end
    drive_zero();
    rst_n = 1'b1;
    m_mie = 1'b0; m_mpie = 1'b0;
  endtask

  task automatic test_exception();
    do_txn(1'b1, 4'd2, 32'h100, 1'b0, '0, '0, '0, 32'h8000, '0);
    vectors++;
    if (seen_mepc !== 32'h100 || seen_mcause !== 32'h2 || seen_rpc !== 32'h8000 || bus.mstatus_mie !== 1'b0) begin
      miscompares++;
      $display("FAIL exception mepc=%h mcause=%h rpc=%h mie=%b exp 100/2/8000/0",
               seen_mepc, seen_mcause, seen_rpc, bus.mstatus_mie);
    end
  endtask

  task automatic test_vectored_irq();
    set_mie_on();
    do_txn(1'b0, '0, '0, 1'b0, 3'b010, 32'h204, 32'h80, 32'h8001, '0);
    vectors++;
    if (seen_mcause !== 32'h8000_0007 || seen_mepc !== 32'h204 || seen_rpc !== 32'h801C) begin
      miscompares++;
      $display("FAIL vectored_mti mcause=%h mepc=%h rpc=%h exp 80000007/204/801c",
               seen_mcause, seen_mepc, seen_rpc);
    end
  endtask

  task automatic test_priority();
    set_mie_on();
    do_txn(1'b1, 4'd11, 32'h500, 1'b0, 3'b111, 32'h600, 32'h888, 32'h8000, '0);
    vectors++;
    if (seen_mcause !== 32'h0000_000B || seen_mepc !== 32'h500) begin
      miscompares++;
      $display("FAIL prio_exc mcause=%h mepc=%h exp 0000000b/500", seen_mcause, seen_mepc);
    end
    do_txn(1'b0, '0, '0, 1'b1, 3'b111, 32'h600, 32'h888, 32'h8000, 32'h504);
    do_txn(1'b0, '0, '0, 1'b0, 3'b111, 32'h600, 32'h888, 32'h8000, '0);
    vectors++;
    if (seen_mcause !== 32'h8000_000B || seen_mepc !== 32'h600) begin
      miscompares++;
      $display("FAIL prio_mei mcause=%h mepc=%h exp 8000000b/600", seen_mcause, seen_mepc);
    end
    set_mie_on();
    do_txn(1'b0, '0, '0, 1'b0, 3'b011, 32'h608, 32'h888, 32'h8001, '0);
    vectors++;
    if (seen_mcause !== 32'h8000_0003 || seen_rpc !== 32'h800C) begin
      miscompares++;
      $display("FAIL prio_msi mcause=%h rpc=%h exp 80000003/800c", seen_mcause, seen_rpc);
    end
  endtask

  task automatic test_mie_off();
    int busy_cnt;
    do_txn(1'b1, 4'd4, 32'h20, 1'b0, '0, '0, '0, 32'h8000, '0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      do_txn(1'b0, '0, '0, 1'b0, 3'b111, 32'h900, '1, 32'h8000, '0);
      if (bus.busy !== 1'b0) busy_cnt++;
    end
    vectors++;
    if (busy_cnt != 0) begin
      miscompares++;
      $display("FAIL mie_off busy_cycles=%0d exp 0", busy_cnt);
    end
  endtask

  task automatic test_mret();
    set_mie_on();
    do_txn(1'b0, '0, '0, 1'b1, '0, '0, '0, 32'h8000, 32'h300);
    vectors++;
    if (seen_rpc !== 32'h300 || bus.mstatus_mie !== 1'b1 || bus.mstatus_mpie !== 1'b1) begin
      miscompares++;
      $display("FAIL mret rpc=%h mie=%b mpie=%b exp 300/1/1", seen_rpc, bus.mstatus_mie, bus.mstatus_mpie);
    end
    do_txn(1'b1, 4'd5, 32'h700, 1'b1, '0, '0, '0, 32'h8000, 32'h300);
    vectors++;
    if (seen_mcause !== 32'h5 || seen_mepc !== 32'h700 || seen_rpc !== 32'h8000) begin
      miscompares++;
      $display("FAIL mret_with_exc mcause=%h mepc=%h rpc=%h exp 5/700/8000", seen_mcause, seen_mepc, seen_rpc);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    set_mie_on();
    bus.exc_valid = 1'b1; bus.exc_code = 4'd6; bus.exc_pc = 32'hA00;
    bus.mtvec = 32'h8000;
    @(posedge clk); #1;
    drive_zero();
    bus.mtvec = 32'h8000;
    @(posedge clk); #3;
    vectors++;
    if (bus.csr_wenable !== 1'b1 || bus.csr_waddr !== MCAUSE_A) begin
      miscompares++;
      $display("FAIL rstmid_pre wen=%b addr=%h exp 1/%h", bus.csr_wenable, bus.csr_waddr, MCAUSE_A);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async got=%h exp=0", obs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_mie = 1'b0; m_mpie = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #3;
      if (bus.csr_wenable !== 1'b0 || bus.redirect_valid !== 1'b0 ||
          bus.mstatus_mie !== 1'b0 || bus.mstatus_mpie !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rstmid_after bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      do_txn($urandom_range(0, 3) == 0, 4'($urandom), $urandom, $urandom_range(0, 2) == 0,
             3'($urandom), $urandom, $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_exception();
    test_vectored_irq();
    test_priority();
    test_mie_off();
    test_mret();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
